// File: rtl/muldiv_scheduler_if.sv
// Pipeline-side bundle for the HI/LO multiply/divide sequencer: issue, HI/LO
// access requests from ID/EX, and the result/hazard signals fed back.
interface muldiv_scheduler_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             read_hilo;
    logic             write_hi;
    logic             write_lo;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op, operand_a, operand_b, read_hilo, write_hi, write_lo, write_data,
        input  hi, lo, busy, stall, done, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b, read_hilo, write_hi, write_lo, write_data,
        output hi, lo, busy, stall, done, div_by_zero
    );
endinterface

// File: rtl/muldiv_scheduler.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO: one shift-add or
// restoring-divide step per cycle on operand magnitudes, sign fix-up at the end.
module muldiv_scheduler #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               rst,
    muldiv_scheduler_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]    count;
    logic             op_div;
    logic             neg_main;
    logic             neg_rem;
    logic             div_zero;
    logic [WIDTH-1:0] raw_a;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lower;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
    logic             dbz_q;
    logic             busy;

    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] lower_step;

    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_fix;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // op[0]=0 selects the signed variants; magnitudes are taken up front
    assign is_signed = ~bus.op[0];
    assign a_neg     = is_signed & bus.operand_a[WIDTH-1];
    assign b_neg     = is_signed & bus.operand_b[WIDTH-1];
    assign a_mag_in  = a_neg ? -bus.operand_a : bus.operand_a;
    assign b_mag_in  = b_neg ? -bus.operand_b : bus.operand_b;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (count == CW'(WIDTH - 1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Multiply shifts {acc,lower} right while adding b_mag; divide shifts left
    // and keeps the trial subtraction when it does not borrow (bit WIDTH clear).
    always_comb begin
        add_sum    = {1'b0, acc} + (lower[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});
        shifted    = {acc, lower[WIDTH-1]};
        diff       = shifted - {1'b0, b_mag};
        acc_step   = add_sum[WIDTH:1];
        lower_step = {add_sum[0], lower[WIDTH-1:1]};
        if (op_div) begin
            if (!diff[WIDTH]) begin
                acc_step   = diff[WIDTH-1:0];
                lower_step = {lower[WIDTH-2:0], 1'b1};
            end else begin
                acc_step   = shifted[WIDTH-1:0];
                lower_step = {lower[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        product     = {acc, lower};
        product_fix = neg_main ? -product : product;
        quotient    = neg_main ? -lower : lower;
        remainder   = neg_rem ? -acc : acc;
        res_hi      = product_fix[2*WIDTH-1:WIDTH];
        res_lo      = product_fix[WIDTH-1:0];
        if (op_div) begin
            if (div_zero) begin
                res_hi = raw_a;
                res_lo = {WIDTH{1'b1}};
            end else begin
                res_hi = remainder;
                res_lo = quotient;
            end
        end
    end

    // A start in IDLE takes priority over a same-cycle MTHI/MTLO
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            op_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            raw_a    <= '0;
            b_mag    <= '0;
            acc      <= '0;
            lower    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        count    <= '0;
                        op_div   <= bus.op[1];
                        neg_main <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= (bus.operand_b == '0);
                        raw_a    <= bus.operand_a;
                        b_mag    <= b_mag_in;
                        acc      <= '0;
                        lower    <= a_mag_in;
                    end else begin
                        if (bus.write_hi) begin
                            hi_q <= bus.write_data;
                        end
                        if (bus.write_lo) begin
                            lo_q <= bus.write_data;
                        end
                    end
                end
                RUN: begin
                    acc   <= acc_step;
                    lower <= lower_step;
                    count <= count + CW'(1);
                end
                FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                    dbz_q  <= op_div & div_zero;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.busy        = busy;
    assign bus.stall       = busy & (bus.start | bus.read_hilo | bus.write_hi | bus.write_lo);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Randomised and directed bench for muldiv_scheduler; results are predicted
// with plain 64-bit and 32-bit arithmetic on the operand values.
module tb_muldiv_scheduler;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    muldiv_scheduler_if #(.WIDTH(W)) bus ();

    muldiv_scheduler #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [1:0]  dir_op  [9] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b10};
    logic [31:0] dir_a   [9] = '{32'h0000FFFF, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'd100, 32'h12345678,
                                 32'h80000000, 32'h80000000, 32'h80000000, 32'd7};
    logic [31:0] dir_b   [9] = '{32'h00010001, 32'd3, 32'd2, 32'd7, 32'd0,
                                 32'hFFFFFFFF, 32'd0, 32'h80000000, 32'hFFFFFFFE};
    logic [31:0] dir_hi  [9] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'h12345678,
                                 32'h0, 32'h80000000, 32'h40000000, 32'd1};
    logic [31:0] dir_lo  [9] = '{32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFFD, 32'd14, 32'hFFFFFFFF,
                                 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFD};
    logic        dir_dbz [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.op         = 2'b00;
        bus.operand_a  = '0;
        bus.operand_b  = '0;
        bus.read_hilo  = 1'b0;
        bus.write_hi   = 1'b0;
        bus.write_lo   = 1'b0;
        bus.write_data = '0;
    endtask

    // {HI,LO} as the architecture defines it
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa;
        int              sb;
        logic [63:0]     r;
        r = '0;
        case (op)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                r  = sp;
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                r  = up;
            end
            2'b10: begin
                if (b == 32'd0) begin
                    r = {a, 32'hFFFFFFFF};
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    r = {32'h0, 32'h80000000};
                end else begin
                    sa = a;
                    sb = b;
                    r  = {32'(sa % sb), 32'(sa / sb)};
                end
            end
            default: begin
                if (b == 32'd0) begin
                    r = {a, 32'hFFFFFFFF};
                end else begin
                    r = {a % b, a / b};
                end
            end
        endcase
        return r;
    endfunction

    // Issues one op from IDLE and observes W+3 cycles after the start edge
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cycles, output int done_count, output int done_at,
                          output int dbz_count, output int dbz_at,
                          output logic [31:0] hi_seen, output logic [31:0] lo_seen);
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        step();
        bus.start     = 1'b0;
        bus.op        = 2'($urandom);
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
        busy_cycles = 0;
        done_count  = 0;
        done_at     = -1;
        dbz_count   = 0;
        dbz_at      = -1;
        hi_seen     = '0;
        lo_seen     = '0;
        for (int k = 0; k <= W + 2; k++) begin
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                done_count++;
                done_at = k;
                hi_seen = bus.hi;
                lo_seen = bus.lo;
            end
            if (bus.div_by_zero) begin
                dbz_count++;
                dbz_at = k;
            end
            if (k != W + 2) step();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        tests_run++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_hilo: got %h_%h expected 0_0", bus.hi, bus.lo);
        end
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got busy=%b done=%b dbz=%b expected 0 0 0",
                     bus.busy, bus.done, bus.div_by_zero);
        end
        rst = 1'b0;
        bus.read_hilo = 1'b1;
        #1;
        tests_run++;
        if (bus.stall !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall);
        end
        bus.read_hilo = 1'b0;
        step();
    endtask

    task automatic test_directed();
        int          busy_cycles, done_count, done_at, dbz_count, dbz_at;
        logic [31:0] hi_seen, lo_seen;
        for (int i = 0; i < 9; i++) begin
            run_op(dir_op[i], dir_a[i], dir_b[i], busy_cycles, done_count, done_at,
                   dbz_count, dbz_at, hi_seen, lo_seen);
            tests_run++;
            if (busy_cycles != W + 1) begin
                tests_failed++;
                $display("[TB] FAIL dir%0d_busy_cycles: got %0d expected %0d", i, busy_cycles, W + 1);
            end
            tests_run++;
            if (done_count != 1 || done_at != W + 1) begin
                tests_failed++;
                $display("[TB] FAIL dir%0d_done_pulse: got count=%0d at=%0d expected 1 at %0d",
                         i, done_count, done_at, W + 1);
            end
            tests_run++;
            if (hi_seen !== dir_hi[i] || lo_seen !== dir_lo[i]) begin
                tests_failed++;
                $display("[TB] FAIL dir%0d_result: got %h_%h expected %h_%h",
                         i, hi_seen, lo_seen, dir_hi[i], dir_lo[i]);
            end
            tests_run++;
            if (dbz_count != (dir_dbz[i] ? 1 : 0) || (dir_dbz[i] && dbz_at != W + 1)) begin
                tests_failed++;
                $display("[TB] FAIL dir%0d_div_by_zero: got count=%0d at=%0d expected %0d at %0d",
                         i, dbz_count, dbz_at, dir_dbz[i], W + 1);
            end
        end
    endtask

    task automatic test_random();
        int          busy_cycles, done_count, done_at, dbz_count, dbz_at;
        logic [31:0] hi_seen, lo_seen, a, b;
        logic [1:0]  op;
        logic [63:0] exp;
        int          exp_dbz;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = -$urandom_range(1, 15);
                3: a = $urandom_range(0, 255);
                default: ;
            endcase
            exp     = ref_result(op, a, b);
            exp_dbz = (op[1] && b == 32'd0) ? 1 : 0;
            run_op(op, a, b, busy_cycles, done_count, done_at, dbz_count, dbz_at, hi_seen, lo_seen);
            tests_run++;
            if ({hi_seen, lo_seen} !== exp || done_at != W + 1) begin
                tests_failed++;
                $display("[TB] FAIL rand%0d_result: op=%b a=%h b=%h got %h_%h at %0d expected %h_%h at %0d",
                         i, op, a, b, hi_seen, lo_seen, done_at, exp[63:32], exp[31:0], W + 1);
            end
            tests_run++;
            if (dbz_count != exp_dbz) begin
                tests_failed++;
                $display("[TB] FAIL rand%0d_div_by_zero: got %0d expected %0d", i, dbz_count, exp_dbz);
            end
        end
    endtask

    task automatic test_read_stall();
        logic [31:0] a, b;
        logic [63:0] exp;
        int          bad;
        a   = -($urandom_range(1, 1000));
        b   = $urandom;
        exp = ref_result(2'b00, a, b);
        bad = 0;
        bus.start     = 1'b1;
        bus.op        = 2'b00;
        bus.operand_a = a;
        bus.operand_b = b;
        step();
        bus.start = 1'b0;
        step();
        bus.read_hilo = 1'b1;
        for (int k = 1; k <= W; k++) begin
            #1;
            if (bus.stall !== 1'b1) bad++;
            step();
        end
        #1;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL read_stall_busy: got %0d unstalled busy cycles expected 0", bad);
        end
        tests_run++;
        if (bus.stall !== 1'b0 || bus.done !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL read_stall_done_cycle: got stall=%b done=%b expected 0 1", bus.stall, bus.done);
        end
        tests_run++;
        if ({bus.hi, bus.lo} !== exp) begin
            tests_failed++;
            $display("[TB] FAIL read_stall_value: got %h_%h expected %h_%h",
                     bus.hi, bus.lo, exp[63:32], exp[31:0]);
        end
        bus.read_hilo = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2;
        logic [63:0] exp1, exp2;
        int          bad_stall, done_at;
        a1 = $urandom; b1 = $urandom;
        a2 = $urandom; b2 = $urandom_range(1, 50000);
        exp1 = ref_result(2'b01, a1, b1);
        exp2 = ref_result(2'b11, a2, b2);
        bad_stall = 0;
        bus.start     = 1'b1;
        bus.op        = 2'b01;
        bus.operand_a = a1;
        bus.operand_b = b1;
        step();
        bus.op        = 2'b11;
        bus.operand_a = a2;
        bus.operand_b = b2;
        for (int k = 0; k <= W; k++) begin
            #1;
            if (bus.stall !== 1'b1 || bus.busy !== 1'b1) bad_stall++;
            step();
        end
        #1;
        tests_run++;
        if (bad_stall != 0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_stall_busy: got %0d bad busy cycles expected 0", bad_stall);
        end
        tests_run++;
        if (bus.stall !== 1'b0 || bus.done !== 1'b1 || {bus.hi, bus.lo} !== exp1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first_done: got stall=%b done=%b %h_%h expected 0 1 %h_%h",
                     bus.stall, bus.done, bus.hi, bus.lo, exp1[63:32], exp1[31:0]);
        end
        step();
        bus.start = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second_accept: got busy=%b expected 1", bus.busy);
        end
        done_at = -1;
        for (int k = 0; k <= W + 3 && done_at < 0; k++) begin
            if (bus.done === 1'b1) done_at = k;
            else step();
        end
        tests_run++;
        if (done_at != W + 1 || {bus.hi, bus.lo} !== exp2) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second_result: got %h_%h at %0d expected %h_%h at %0d",
                     bus.hi, bus.lo, done_at, exp2[63:32], exp2[31:0], W + 1);
        end
        step();
    endtask

    task automatic test_idle_writes();
        logic [31:0] d1, d2, a, b;
        logic [63:0] exp;
        int          done_at;
        d1 = $urandom; d2 = $urandom;
        bus.write_hi   = 1'b1;
        bus.write_data = d1;
        #1;
        tests_run++;
        if (bus.stall !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mthi_idle_stall: got %b expected 0", bus.stall);
        end
        step();
        bus.write_hi   = 1'b0;
        bus.write_lo   = 1'b1;
        bus.write_data = d2;
        step();
        bus.write_lo = 1'b0;
        tests_run++;
        if (bus.hi !== d1 || bus.lo !== d2) begin
            tests_failed++;
            $display("[TB] FAIL mthi_mtlo_idle: got %h_%h expected %h_%h", bus.hi, bus.lo, d1, d2);
        end
        a = $urandom; b = $urandom_range(1, 1000);
        exp = ref_result(2'b11, a, b);
        bus.start      = 1'b1;
        bus.op         = 2'b11;
        bus.operand_a  = a;
        bus.operand_b  = b;
        bus.write_lo   = 1'b1;
        bus.write_data = ~d2;
        step();
        bus.start    = 1'b0;
        bus.write_lo = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b1 || bus.lo !== d2) begin
            tests_failed++;
            $display("[TB] FAIL start_beats_write: got busy=%b lo=%h expected 1 %h", bus.busy, bus.lo, d2);
        end
        bus.write_hi = 1'b1;
        #1;
        tests_run++;
        if (bus.stall !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mthi_busy_stall: got %b expected 1", bus.stall);
        end
        bus.write_hi = 1'b0;
        done_at = -1;
        for (int k = 0; k <= W + 3 && done_at < 0; k++) begin
            if (bus.done === 1'b1) done_at = k;
            else step();
        end
        tests_run++;
        if (done_at != W + 1 || {bus.hi, bus.lo} !== exp) begin
            tests_failed++;
            $display("[TB] FAIL start_beats_write_result: got %h_%h at %0d expected %h_%h at %0d",
                     bus.hi, bus.lo, done_at, exp[63:32], exp[31:0], W + 1);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        int dones;
        int busies;
        bus.start     = 1'b1;
        bus.op        = 2'b01;
        bus.operand_a = 32'hFFFFFFFF;
        bus.operand_b = 32'hFFFFFFFF;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 9; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_run: got busy=%b done=%b %h_%h expected 0 0 0_0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        dones  = 0;
        busies = 0;
        for (int k = 0; k < W + 8; k++) begin
            if (bus.done === 1'b1) dones++;
            if (bus.busy === 1'b1) busies++;
            step();
        end
        tests_run++;
        if (dones != 0 || busies != 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_run_quiet: got done=%0d busy=%0d cycles expected 0 0", dones, busies);
        end
        bus.write_lo   = 1'b1;
        bus.write_data = 32'h0000ABCD;
        step();
        bus.write_lo = 1'b0;
        tests_run++;
        if (bus.lo !== 32'h0000ABCD || bus.hi !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL mtlo_after_reset: got %h_%h expected 00000000_0000abcd", bus.hi, bus.lo);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_directed();
        test_random();
        test_read_stall();
        test_back_to_back();
        test_idle_writes();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
